// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: control-word bit positions,
// the "no side effect" control value and the skid-buffer occupancy states.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF    = 8;

    localparam int unsigned CTRL_REGWR    = 0;
    localparam int unsigned CTRL_MEMWR    = 1;
    localparam int unsigned CTRL_MEMTOREG = 2;
    localparam int unsigned CTRL_EXC      = 3;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_JUMP     = 5;
    localparam int unsigned CTRL_MEMRD    = 6;
    localparam int unsigned CTRL_ALUSRC   = 7;

    // An all-zero control word is a bubble: it must never write a register or memory.
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid store (main + skid) with a registered in_ready, used when PIPE_SKID_EN
// is defined. State updates on the falling clock edge; flush empties both entries.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CTRL_W     = 8,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    occ_state_t        state_q, state_d;
    logic [WIDTH-1:0]  mainData_q, mainData_d, skidData_q, skidData_d;
    logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d, skidCtrl_q, skidCtrl_d;
    logic              inReady_q;
    logic              accept, consume;

    assign accept  = in_valid & inReady_q & ~flush;
    assign consume = (state_q != EMPTY) & out_ready & ~flush;

    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainCtrl_d = mainCtrl_q;
        skidData_d = skidData_q;
        skidCtrl_d = skidCtrl_q;
        if (flush) begin
            state_d    = EMPTY;
            mainCtrl_d = '0;
            skidCtrl_d = '0;
            if (CLEAR_DATA) begin
                mainData_d = '0;
                skidData_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        mainData_d = in_data;
                        mainCtrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        mainData_d = in_data;
                        mainCtrl_d = in_ctrl;
                    end else if (accept) begin
                        state_d    = FULL;
                        skidData_d = in_data;
                        skidCtrl_d = in_ctrl;
                    end else if (consume) begin
                        state_d    = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry is older than anything upstream, so it moves to main first.
                    if (consume) begin
                        state_d    = ONE;
                        mainData_d = skidData_q;
                        mainCtrl_d = skidCtrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainCtrl_q <= '0;
            skidData_q <= '0;
            skidCtrl_q <= '0;
            inReady_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainCtrl_q <= mainCtrl_d;
            skidData_q <= skidData_d;
            skidCtrl_q <= skidCtrl_d;
            inReady_q  <= (state_d != FULL);
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = mainData_q;
    assign out_ctrl  = mainCtrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, flush and bubble clearing.
// Define PIPE_SKID_EN for the two-entry skid build; otherwise a single-entry register.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CTRL_W     = 8,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              stValid;
    logic [WIDTH-1:0]  stData;
    logic [CTRL_W-1:0] stCtrl;

`ifdef PIPE_SKID_EN
    pipe_skid_buf #(
        .WIDTH      (WIDTH),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (stValid),
        .out_ready (out_ready),
        .out_data  (stData),
        .out_ctrl  (stCtrl)
    );
`else
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              accept, consume;

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign consume  = valid_q & out_ready & ~flush;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_DATA) begin
                data_d = '0;
            end
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(negedge clk or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign stValid = valid_q;
    assign stData  = data_q;
    assign stCtrl  = ctrl_q;
`endif

    // Whatever sits in storage, an invalid slot must look like a harmless bubble downstream.
    assign out_valid = stValid;
    assign out_ctrl  = stValid ? stCtrl : CTRL_W'(CTRL_BUBBLE);
    assign out_data  = (stValid || !CLEAR_DATA) ? stData : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based reference model;
// follows PIPE_SKID_EN to pick depth 2 / registered in_ready or depth 1 / combinational in_ready.
module tb_pipe_stage_reg;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 8;
`ifdef PIPE_SKID_EN
    localparam int DEPTH  = 2;
`else
    localparam int DEPTH  = 1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    logic              clk;
    logic              Reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [CTRL_W-1:0] out_ctrl;

    pipe_stage_reg #(
        .WIDTH      (WIDTH),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (1'b1)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    entry_t modelQ[$];
    bit     modelReadyReg;
    bit     dataZero;
    bit     lastAccepted;
    int     total;
    int     bad;

    function automatic bit modelInReady();
        if (DEPTH == 2) return modelReadyReg;
        return (modelQ.size() == 0) || out_ready;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle: drive at posedge, compare just after, advance the model on the falling edge.
    task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [7:0] c,
                                 input bit r, input bit f, input string tag);
        bit rdy;
        entry_t e;
        @(posedge clk);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        #1;
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(modelQ.size() > 0));
        if (modelQ.size() > 0) begin
            checkOutput({tag, ".out_data"}, out_data, modelQ[0].data);
            checkOutput({tag, ".out_ctrl"}, 32'(out_ctrl), 32'(modelQ[0].ctrl));
        end else begin
            checkOutput({tag, ".bubble_ctrl"}, 32'(out_ctrl), 32'h0);
            if (dataZero) checkOutput({tag, ".cleared_data"}, out_data, 32'h0);
        end
        rdy = modelInReady();
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        @(negedge clk);
        lastAccepted = 1'b0;
        if (f) begin
            modelQ.delete();
            dataZero = 1'b1;
        end else begin
            if (modelQ.size() > 0 && r) void'(modelQ.pop_front());
            if (v && rdy) begin
                e.data = d;
                e.ctrl = c;
                modelQ.push_back(e);
                lastAccepted = 1'b1;
                dataZero = 1'b0;
            end
        end
        modelReadyReg = (modelQ.size() < 2);
    endtask

    // Reset asserted between edges; outputs must clear at once, in_ready follows the build.
    task automatic doReset();
        @(posedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2 Reset = 1'b1;
        #1;
        modelQ.delete();
        dataZero      = 1'b1;
        modelReadyReg = 1'b0;
        checkOutput("rst.out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst.out_ctrl", 32'(out_ctrl), 32'h0);
        checkOutput("rst.out_data", out_data, 32'h0);
        @(posedge clk);
        #2 Reset = 1'b0;
        #1;
        checkOutput("rst.in_ready_release", 32'(in_ready), (DEPTH == 2) ? 32'h0 : 32'h1);
        @(negedge clk);
        modelReadyReg = 1'b1;
    endtask

    initial begin
        int idx;
        bit pv;
        logic [31:0] pd;
        logic [7:0]  pc;
        logic [31:0] abc [3];

        total = 0;
        bad   = 0;
        Reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_ctrl  = '0;
        out_ready = 1'b0;
        modelReadyReg = 1'b0;
        dataZero = 1'b1;
        lastAccepted = 1'b0;

        doReset();

        // Test 1: fill the store, reset mid-cycle, nothing must replay afterwards.
        applyStimulus(1'b1, 32'h11, 8'h81, 1'b0, 1'b0, "t1.fill");
        applyStimulus(1'b1, 32'h22, 8'h82, 1'b0, 1'b0, "t1.fill");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, "t1.noreplay");

        // Test 2: streaming with downstream always ready.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'(i), 8'(i), 1'b1, 1'b0, "t2.stream");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, "t2.drain");

        // Test 3: backpressure for three cycles; upstream holds its word until accepted.
        abc[0] = 32'hA; abc[1] = 32'hB; abc[2] = 32'hC;
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            applyStimulus(idx < 3, (idx < 3) ? abc[idx] : 32'h0, 8'h03, cyc >= 3, 1'b0, "t3.stall");
            if (lastAccepted) idx++;
        end
        checkOutput("t3.all_accepted", 32'(idx), 32'd3);

        // Test 4: flush while full with a same-edge offer that must be rejected.
        applyStimulus(1'b1, 32'h31, 8'h11, 1'b0, 1'b0, "t4.fill");
        applyStimulus(1'b1, 32'h32, 8'h12, 1'b0, 1'b0, "t4.fill");
        applyStimulus(1'b1, 32'h55, 8'hFF, 1'b0, 1'b1, "t4.flush");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 8'hFF, 1'b1, 1'b0, "t4.after");

        // Test 5: control bits offered without valid never reach the output.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h77, 8'hFF, i[0], 1'b0, "t5.bubble");

        // Test 6: random traffic against the model.
        pv = 1'b0;
        pd = '0;
        pc = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bit f;
            bit r;
            if (!pv && $urandom_range(0, 9) < 7) begin
                pv = 1'b1;
                pd = $urandom;
                pc = 8'($urandom);
            end
            f = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 9) < 6);
            applyStimulus(pv, pd, pc, r, f, "t6.rand");
            if (lastAccepted || f) pv = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
